// File: rtl/fetch_stage32.sv
// KLP32 instruction fetch stage: owns the PC, addresses the combinational instruction
// memory and fills the IF/ID register under stall, flush and redirect control from decode/execute.
module fetch_stage32 #(
    parameter int unsigned    n        = 32,
    parameter logic [n-1:0]   RESET_PC = 32'h0000_0000,
    parameter logic [n-1:0]   NOP_INST = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         flush,
    input  logic         redirect_valid,
    input  logic [n-1:0] redirect_pc,
    output logic [n-1:0] imem_addr,
    input  logic [n-1:0] imem_inst,
    output logic [n-1:0] ifid_inst,
    output logic [n-1:0] ifid_pc,
    output logic [n-1:0] ifid_pc4,
    output logic         ifid_valid,
    output logic         misalign_err,
    output logic [31:0]  fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    fetch_state_e state_q;
    logic [n-1:0] pc_q;
    logic [n-1:0] pc_plus4;
    logic [n-1:0] ifid_inst_q;
    logic [n-1:0] ifid_pc_q;
    logic [n-1:0] ifid_pc4_q;
    logic         ifid_valid_q;
    logic         misalign_q;
    logic [31:0]  fetch_count_q;
    logic         redirect_misaligned;

    // Wraps modulo 2^n; a fetch past the top of the address space simply restarts at 0.
    assign pc_plus4            = pc_q + n'(4);
    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

    // Driven from the PC register only, so the memory address never depends on same-cycle inputs.
    assign imem_addr = {2'b00, pc_q[n-1:2]};

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            ifid_inst_q   <= NOP_INST;
            ifid_pc_q     <= '0;
            ifid_pc4_q    <= '0;
            ifid_valid_q  <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    if (redirect_valid && redirect_misaligned) begin
                        misalign_q   <= 1'b1;
                        state_q      <= HALT;
                        ifid_inst_q  <= NOP_INST;
                        ifid_valid_q <= 1'b0;
                    end else if (redirect_valid) begin
                        pc_q         <= redirect_pc;
                        ifid_inst_q  <= NOP_INST;
                        ifid_valid_q <= 1'b0;
                    end else if (flush) begin
                        // The word fetched this cycle is dropped; PC still advances unless stalled.
                        ifid_inst_q  <= NOP_INST;
                        ifid_valid_q <= 1'b0;
                        if (!stall) pc_q <= pc_plus4;
                    end else if (!stall) begin
                        ifid_inst_q   <= imem_inst;
                        ifid_pc_q     <= pc_q;
                        ifid_pc4_q    <= pc_plus4;
                        ifid_valid_q  <= 1'b1;
                        pc_q          <= pc_plus4;
                        fetch_count_q <= fetch_count_q + 32'd1;
                    end
                end
                HALT: state_q <= HALT;
                default: state_q <= HALT;
            endcase
        end
    end

    assign ifid_inst    = ifid_inst_q;
    assign ifid_pc      = ifid_pc_q;
    assign ifid_pc4     = ifid_pc4_q;
    assign ifid_valid   = ifid_valid_q;
    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;

endmodule
